// File: rtl/race_game_ctrl.sv
// Frame-synchronous game sequencer for the retro racer: game FSM plus every
// sprite/background position register consumed by the VGA sprite renderer.
module race_game_ctrl #(
  parameter int unsigned pixel_counter_width = 10,
  parameter int unsigned CAR_X_MIN           = 244,
  parameter int unsigned CAR_X_MAX           = 304,
  parameter int unsigned CAR_Y               = 380,
  parameter int unsigned CAR_STEP            = 4,
  parameter int unsigned RIVAL_X_MIN         = 244,
  parameter int unsigned RIVAL_Y_START       = 150,
  parameter int unsigned RIVAL_Y_END         = 430,
  parameter int unsigned RIVAL_STEP          = 2,
  parameter int unsigned SCROLL_STEP         = 1,
  parameter int unsigned BG_HEIGHT           = 320
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           btn_left_p,
  input  logic                           btn_right_p,
  input  logic                           btn_center_p,
  input  logic [7:0]                     random_value,
  input  logic                           collision,
  output logic [2:0]                     current_state,
  output logic [pixel_counter_width-1:0] car_x_pos,
  output logic [pixel_counter_width-1:0] car_y_pos,
  output logic [pixel_counter_width-1:0] rival_x_pos,
  output logic [pixel_counter_width-1:0] rival_y_pos,
  output logic                           rival_active,
  output logic [pixel_counter_width-1:0] bg_scroll_offset,
  output logic [7:0]                     score,
  output logic                           game_over
);

  localparam int unsigned W = pixel_counter_width;

  localparam logic [W-1:0] CAR_X_MIN_V   = W'(CAR_X_MIN);
  localparam logic [W-1:0] CAR_X_MAX_V   = W'(CAR_X_MAX);
  localparam logic [W-1:0] CAR_X_RESET_V = W'((CAR_X_MIN + CAR_X_MAX) / 2);
  localparam logic [W-1:0] CAR_Y_V       = W'(CAR_Y);
  localparam logic [W-1:0] CAR_STEP_V    = W'(CAR_STEP);
  localparam logic [W-1:0] RIVAL_X_MIN_V = W'(RIVAL_X_MIN);
  localparam logic [W-1:0] RIVAL_Y_ST_V  = W'(RIVAL_Y_START);
  localparam logic [W:0]   RIVAL_Y_END_V = (W+1)'(RIVAL_Y_END);
  localparam logic [W:0]   RIVAL_STEP_V  = (W+1)'(RIVAL_STEP);
  localparam logic [W:0]   SCROLL_STEP_V = (W+1)'(SCROLL_STEP);
  localparam logic [W:0]   BG_HEIGHT_V   = (W+1)'(BG_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPAWN   = 3'd1,
    S_RUN     = 3'd2,
    S_RESPAWN = 3'd3,
    S_COLLIDE = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] car_x_q, car_x_d;
  logic [W-1:0] rival_x_q, rival_x_d;
  logic [W-1:0] rival_y_q, rival_y_d;
  logic         rival_active_q, rival_active_d;
  logic [W-1:0] scroll_q, scroll_d;
  logic [7:0]   score_q, score_d;
  logic         game_over_q, game_over_d;
  logic         coll_seen_q, coll_seen_d;

  logic [W-1:0] car_x_moved_c;
  logic [W:0]   rival_y_next_c;
  logic [W:0]   scroll_sum_c;
  logic [W-1:0] scroll_next_c;
  logic [5:0]   rnd_c;
  logic [W-1:0] spawn_x_c;
  logic [7:0]   score_inc_c;
  logic         unused_rnd_c;

  // Only the low six random bits select the spawn lane.
  assign unused_rnd_c = ^random_value[7:6];

  // Car steering: opposing pulses cancel, edges clamp to the road.
  always_comb begin
    car_x_moved_c = car_x_q;
    if (btn_left_p && !btn_right_p) begin
      car_x_moved_c = (car_x_q < CAR_X_MIN_V + CAR_STEP_V) ? CAR_X_MIN_V : car_x_q - CAR_STEP_V;
    end else if (btn_right_p && !btn_left_p) begin
      car_x_moved_c = (car_x_q + CAR_STEP_V > CAR_X_MAX_V) ? CAR_X_MAX_V : car_x_q + CAR_STEP_V;
    end
  end

  // Per-frame arithmetic, computed one bit wider so limits compare without overflow.
  always_comb begin
    rival_y_next_c = {1'b0, rival_y_q} + RIVAL_STEP_V;
    scroll_sum_c   = {1'b0, scroll_q} + SCROLL_STEP_V;
    scroll_next_c  = (scroll_sum_c >= BG_HEIGHT_V) ? W'(scroll_sum_c - BG_HEIGHT_V)
                                                   : scroll_sum_c[W-1:0];
    rnd_c          = (random_value[5:0] >= 6'd61) ? random_value[5:0] - 6'd61 : random_value[5:0];
    spawn_x_c      = RIVAL_X_MIN_V + W'(rnd_c);
    score_inc_c    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
  end

  // Next-state and register updates.
  always_comb begin
    state_d        = state_q;
    car_x_d        = car_x_q;
    rival_x_d      = rival_x_q;
    rival_y_d      = rival_y_q;
    rival_active_d = rival_active_q;
    scroll_d       = scroll_q;
    score_d        = score_q;
    coll_seen_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (btn_center_p) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        rival_x_d      = spawn_x_c;
        rival_y_d      = RIVAL_Y_ST_V;
        rival_active_d = 1'b1;
        state_d        = S_RUN;
      end
      S_RUN: begin
        car_x_d = car_x_moved_c;
        if (frame_tick) begin
          if (coll_seen_q || (collision && rival_active_q)) begin
            state_d = S_COLLIDE;
          end else if (rival_y_next_c > RIVAL_Y_END_V) begin
            rival_active_d = 1'b0;
            score_d        = score_inc_c;
            scroll_d       = scroll_next_c;
            state_d        = S_RESPAWN;
          end else begin
            rival_y_d = rival_y_next_c[W-1:0];
            scroll_d  = scroll_next_c;
          end
        end else begin
          coll_seen_d = coll_seen_q | (collision & rival_active_q);
        end
      end
      S_RESPAWN: begin
        car_x_d = car_x_moved_c;
        if (frame_tick) begin
          scroll_d = scroll_next_c;
          state_d  = S_SPAWN;
        end
      end
      S_COLLIDE: begin
        if (btn_center_p) begin
          car_x_d  = CAR_X_RESET_V;
          score_d  = 8'd0;
          scroll_d = '0;
          state_d  = S_SPAWN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    game_over_d = (state_d == S_COLLIDE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      car_x_q        <= CAR_X_RESET_V;
      rival_x_q      <= RIVAL_X_MIN_V;
      rival_y_q      <= RIVAL_Y_ST_V;
      rival_active_q <= 1'b0;
      scroll_q       <= '0;
      score_q        <= 8'd0;
      game_over_q    <= 1'b0;
      coll_seen_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      car_x_q        <= car_x_d;
      rival_x_q      <= rival_x_d;
      rival_y_q      <= rival_y_d;
      rival_active_q <= rival_active_d;
      scroll_q       <= scroll_d;
      score_q        <= score_d;
      game_over_q    <= game_over_d;
      coll_seen_q    <= coll_seen_d;
    end
  end

  assign current_state    = state_q;
  assign car_x_pos        = car_x_q;
  assign car_y_pos        = CAR_Y_V;
  assign rival_x_pos      = rival_x_q;
  assign rival_y_pos      = rival_y_q;
  assign rival_active     = rival_active_q;
  assign bg_scroll_offset = scroll_q;
  assign score            = score_q;
  assign game_over        = game_over_q;

endmodule

// File: tb/tb_race_game_ctrl.sv
// Directed bench for race_game_ctrl: expectations queued before each cycle,
// popped and compared one time unit after the clock edge.
module tb_race_game_ctrl;

  localparam int F_STATE  = 0;
  localparam int F_CARX   = 1;
  localparam int F_CARY   = 2;
  localparam int F_RIVX   = 3;
  localparam int F_RIVY   = 4;
  localparam int F_ACTIVE = 5;
  localparam int F_SCROLL = 6;
  localparam int F_SCORE  = 7;
  localparam int F_GO     = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, btn_left_p, btn_right_p, btn_center_p, collision;
  logic [7:0] random_value;
  logic [2:0] current_state;
  logic [9:0] car_x_pos, car_y_pos, rival_x_pos, rival_y_pos, bg_scroll_offset;
  logic       rival_active, game_over;
  logic [7:0] score;

  int    errors = 0;
  int    checks = 0;
  string tag_q[$];
  int    fid_q[$];
  int    exp_q[$];

  race_game_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .frame_tick       (frame_tick),
    .btn_left_p       (btn_left_p),
    .btn_right_p      (btn_right_p),
    .btn_center_p     (btn_center_p),
    .random_value     (random_value),
    .collision        (collision),
    .current_state    (current_state),
    .car_x_pos        (car_x_pos),
    .car_y_pos        (car_y_pos),
    .rival_x_pos      (rival_x_pos),
    .rival_y_pos      (rival_y_pos),
    .rival_active     (rival_active),
    .bg_scroll_offset (bg_scroll_offset),
    .score            (score),
    .game_over        (game_over)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input int fid, input int val);
    tag_q.push_back(tag);
    fid_q.push_back(fid);
    exp_q.push_back(val);
  endtask

  function automatic int observe(input int fid);
    case (fid)
      F_STATE:  return int'(current_state);
      F_CARX:   return int'(car_x_pos);
      F_CARY:   return int'(car_y_pos);
      F_RIVX:   return int'(rival_x_pos);
      F_RIVY:   return int'(rival_y_pos);
      F_ACTIVE: return int'(rival_active);
      F_SCROLL: return int'(bg_scroll_offset);
      F_SCORE:  return int'(score);
      F_GO:     return int'(game_over);
      default:  return -1;
    endcase
  endfunction

  // Drive one cycle of pulses, then check everything queued for this edge.
  task automatic tick(input logic ft, input logic l, input logic r, input logic c, input logic coll);
    frame_tick   = ft;
    btn_left_p   = l;
    btn_right_p  = r;
    btn_center_p = c;
    collision    = coll;
    @(posedge clk);
    #1;
    frame_tick   = 1'b0;
    btn_left_p   = 1'b0;
    btn_right_p  = 1'b0;
    btn_center_p = 1'b0;
    collision    = 1'b0;
    while (tag_q.size() > 0) begin
      string t;
      int    f, e, o;
      t = tag_q.pop_front();
      f = fid_q.pop_front();
      e = exp_q.pop_front();
      o = observe(f);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", t, o, e);
      end
    end
  endtask

  task automatic expect_reset_values(input string tag);
    expect_val({tag, "_state"},  F_STATE,  0);
    expect_val({tag, "_carx"},   F_CARX,   274);
    expect_val({tag, "_cary"},   F_CARY,   380);
    expect_val({tag, "_rivx"},   F_RIVX,   244);
    expect_val({tag, "_rivy"},   F_RIVY,   150);
    expect_val({tag, "_active"}, F_ACTIVE, 0);
    expect_val({tag, "_scroll"}, F_SCROLL, 0);
    expect_val({tag, "_score"},  F_SCORE,  0);
    expect_val({tag, "_go"},     F_GO,     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    random_value = 8'h00;
    frame_tick = 1'b0; btn_left_p = 1'b0; btn_right_p = 1'b0;
    btn_center_p = 1'b0; collision = 1'b0;

    tick(0, 0, 0, 0, 0);
    expect_reset_values("reset");
    tick(0, 0, 0, 0, 0);
    rst = 1'b0;

    // IDLE ignores everything except center
    random_value = 8'hB5;
    expect_val("idle_ignore_state", F_STATE, 0);
    expect_val("idle_ignore_carx", F_CARX, 274);
    tick(1, 0, 1, 0, 1);
    expect_val("start_spawn", F_STATE, 1);
    tick(0, 0, 0, 1, 0);
    expect_val("spawn_b5_run", F_STATE, 2);
    expect_val("spawn_b5_rivx", F_RIVX, 297);
    expect_val("spawn_b5_active", F_ACTIVE, 1);
    expect_val("spawn_b5_rivy", F_RIVY, 150);
    tick(0, 0, 0, 0, 0);

    // Rival descends to the end of the road and respawns
    for (int i = 1; i <= 141; i++) begin
      if (i == 10) begin
        expect_val("run10_rivy", F_RIVY, 170);
        expect_val("run10_scroll", F_SCROLL, 10);
      end
      if (i == 140) begin
        expect_val("run140_state", F_STATE, 2);
        expect_val("run140_rivy", F_RIVY, 430);
      end
      if (i == 141) begin
        expect_val("respawn_state", F_STATE, 3);
        expect_val("respawn_score", F_SCORE, 1);
        expect_val("respawn_active", F_ACTIVE, 0);
        expect_val("respawn_rivy", F_RIVY, 430);
        expect_val("respawn_scroll", F_SCROLL, 141);
      end
      tick(1, 0, 0, 0, 0);
    end

    random_value = 8'hFF;
    expect_val("respawn_right", F_CARX, 278);
    expect_val("respawn_hold", F_STATE, 3);
    tick(0, 0, 1, 0, 0);
    expect_val("respawn_left", F_CARX, 274);
    tick(0, 1, 0, 0, 0);
    expect_val("respawn_tick_spawn", F_STATE, 1);
    expect_val("respawn_tick_scroll", F_SCROLL, 142);
    tick(1, 0, 0, 0, 0);
    expect_val("spawn_ff_run", F_STATE, 2);
    expect_val("spawn_ff_rivx", F_RIVX, 246);
    expect_val("spawn_ff_rivy", F_RIVY, 150);
    expect_val("spawn_ff_active", F_ACTIVE, 1);
    tick(0, 0, 0, 0, 0);

    for (int i = 1; i <= 141; i++) begin
      if (i == 141) begin
        expect_val("respawn2_state", F_STATE, 3);
        expect_val("respawn2_score", F_SCORE, 2);
        expect_val("respawn2_scroll", F_SCROLL, 283);
      end
      tick(1, 0, 0, 0, 0);
    end
    expect_val("respawn2_spawn", F_STATE, 1);
    expect_val("respawn2_scroll_tick", F_SCROLL, 284);
    tick(1, 0, 0, 0, 0);
    expect_val("spawn3_run", F_STATE, 2);
    tick(0, 0, 0, 0, 0);

    // Scroll wraps after 320 advancing ticks
    for (int i = 1; i <= 36; i++) begin
      if (i == 35) expect_val("scroll_319", F_SCROLL, 319);
      if (i == 36) begin
        expect_val("scroll_wrap", F_SCROLL, 0);
        expect_val("scroll_wrap_rivy", F_RIVY, 222);
      end
      tick(1, 0, 0, 0, 0);
    end

    // Steering and clamping
    for (int i = 1; i <= 20; i++) begin
      if (i == 7)  expect_val("right7", F_CARX, 302);
      if (i == 8)  expect_val("right8_clamp", F_CARX, 304);
      if (i == 20) expect_val("right20_clamp", F_CARX, 304);
      tick(0, 0, 1, 0, 0);
    end
    expect_val("both_btn", F_CARX, 304);
    tick(0, 1, 1, 0, 0);
    expect_val("left_with_tick_carx", F_CARX, 300);
    expect_val("left_with_tick_rivy", F_RIVY, 224);
    expect_val("left_with_tick_scroll", F_SCROLL, 1);
    tick(1, 1, 0, 0, 0);
    for (int i = 2; i <= 20; i++) begin
      if (i == 14) expect_val("left14", F_CARX, 248);
      if (i == 15) expect_val("left15_clamp", F_CARX, 244);
      if (i == 20) expect_val("left20_clamp", F_CARX, 244);
      tick(0, 1, 0, 0, 0);
    end

    // Collision mid-frame is latched until the next frame tick
    expect_val("coll_pulse_state", F_STATE, 2);
    tick(0, 0, 0, 0, 1);
    expect_val("coll_wait_state", F_STATE, 2);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    expect_val("collide_state", F_STATE, 4);
    expect_val("collide_go", F_GO, 1);
    expect_val("collide_rivy", F_RIVY, 224);
    expect_val("collide_scroll", F_SCROLL, 1);
    expect_val("collide_score", F_SCORE, 2);
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) begin
        expect_val("frozen_state", F_STATE, 4);
        expect_val("frozen_go", F_GO, 1);
        expect_val("frozen_carx", F_CARX, 244);
        expect_val("frozen_rivy", F_RIVY, 224);
        expect_val("frozen_scroll", F_SCROLL, 1);
        expect_val("frozen_score", F_SCORE, 2);
      end
      tick(1, logic'(i % 2 == 0), logic'(i % 2 == 1), 0, logic'(i < 5));
    end
    random_value = 8'h3D;
    expect_val("restart_state", F_STATE, 1);
    expect_val("restart_score", F_SCORE, 0);
    expect_val("restart_carx", F_CARX, 274);
    expect_val("restart_scroll", F_SCROLL, 0);
    expect_val("restart_go", F_GO, 0);
    tick(0, 0, 0, 1, 0);
    expect_val("spawn_3d_rivx", F_RIVX, 244);
    expect_val("spawn_3d_rivy", F_RIVY, 150);
    expect_val("spawn_3d_state", F_STATE, 2);
    tick(0, 0, 0, 0, 0);

    // Reset wins over a frame tick and a button in the same cycle
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin
        expect_val("pre_rst_rivy", F_RIVY, 156);
        expect_val("pre_rst_scroll", F_SCROLL, 3);
        expect_val("pre_rst_state", F_STATE, 2);
      end
      tick(1, 0, 0, 0, 0);
    end
    expect_val("pre_rst_carx", F_CARX, 278);
    tick(0, 0, 1, 0, 0);
    rst = 1'b1;
    expect_reset_values("midrun_rst");
    tick(1, 0, 1, 0, 0);
    rst = 1'b0;

    random_value = 8'h3C;
    expect_val("post_rst_spawn", F_STATE, 1);
    tick(0, 0, 0, 1, 0);
    expect_val("spawn_3c_rivx", F_RIVX, 304);
    expect_val("spawn_3c_state", F_STATE, 2);
    tick(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
